sdram_rd_checker: RTL
=====================

# sdram_rd_checker

User-side read-back checker for `sdram_interface`, clocked on `clk_50M`. It pulls a programmed number of words from the read FIFO in fixed-length bursts and raises `sdram_rd_valid` to request SDRAM refills. It compares each word against an incrementing reference pattern and reports pass/fail, the error count and the word count. It is the consumer for the write-side traffic generator and is used both in simulation and on-board self-test.

## Interface
Parameters:
- `DATA_W`, 16, width of FIFO data and of the pattern.
- `CNT_W`, 10, width of `rd_fifo_cnt`.
- `BURST`, 10, words drained per burst; range 1..2^CNT_W-1.
- `TOTAL`, 30, words checked per run; must be ≥1.
- `PATTERN_BASE`, 0, expected value of word 0.

Ports:
- `clk_50M`  in  1  FIFO read clock. Reset is `locked_rst_n`: asynchronous, active-low.
- `locked_rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle run request; ignored unless in IDLE or DONE.
- `rd_fifo_cnt`  in  CNT_W  read-FIFO occupancy.
- `fifo_rd_data`  in  DATA_W  FIFO output. Standard (non-FWFT) mode: valid the cycle after `fifo_rd_req`.
- `fifo_rd_req`  out  1  FIFO read strobe, registered.
- `sdram_rd_valid`  out  1  request for the SDRAM side to refill the read FIFO, registered.
- `busy`  out  1  high in ARM, DRAIN or TAIL.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done`; 1 iff `err_cnt == 0`.
- `err_cnt`  out  16  mismatch count, saturates at 16'hFFFF.
- `word_cnt`  out  16  words compared this run.
- `first_err_idx`  out  16  present only with the macro.
- `first_err_data`  out  DATA_W  present only with the macro.

## Operation
- States:
  - IDLE → ARM on `start`.
  - ARM → DRAIN when `rd_fifo_cnt >= burst_len`.
  - DRAIN → TAIL after `burst_len` read cycles.
  - TAIL → ARM if `word_cnt` (after the tail compare) < TOTAL, else → DONE.
  - DONE → ARM on `start`.
- `burst_len` = min(BURST, TOTAL − words issued). A final partial burst is allowed.
- ARM: `sdram_rd_valid` = 1 while `rd_fifo_cnt < burst_len`, 0 otherwise. It is 0 in every other state.
- DRAIN: `fifo_rd_req` = 1 for exactly `burst_len` consecutive cycles, no gaps. It is 0 in all other states.
- Compare strobe `chk_vld` = `fifo_rd_req` delayed 1 cycle. On `chk_vld`:
  - `exp` = PATTERN_BASE + `word_cnt`, mod 2^DATA_W.
  - Mismatch → `err_cnt`+1, saturating.
  - `word_cnt` increments every strobe.
- TAIL lasts one cycle so the last word of a burst is compared before the state is left.
- `start` from IDLE or DONE clears `err_cnt`, `word_cnt` and the first-error registers in the same cycle it moves to ARM.
- `start` in ARM, DRAIN or TAIL is ignored.
- Reset mid-run: every register returns to its reset value immediately (asynchronous). Words already in the FIFO are not flushed; the system must reset the FIFO alongside this block.

## Timing
- Reset values:
  - State IDLE.
  - `fifo_rd_req`, `sdram_rd_valid`, `busy`, `done`, `pass` = 0.
  - `err_cnt`, `word_cnt`, `first_err_*` = 0.
- Cycle after `start`: `busy` = 1; `sdram_rd_valid` reflects the ARM rule one cycle later (registered).
- ARM→DRAIN: `fifo_rd_req` rises on the edge after the condition is sampled true.
- Per burst: `burst_len` DRAIN cycles plus 1 TAIL cycle. Compare results lag the corresponding `fifo_rd_req` by 1 cycle.
- `done` and `pass` update on the same edge as the TAIL→DONE transition. `pass` reflects a last-word mismatch.
- `rd_fifo_cnt` is sampled as delivered. The FIFO must already provide it synchronously to `clk_50M`.

## Configuration
- `SDRAM_RD_CHK_FIRST_ERR_EN` defined:
  - `first_err_idx` / `first_err_data` latch `word_cnt` and `fifo_rd_data` at the first mismatch of the run.
  - They hold until the next `start` or reset.
  - An internal flag blocks later overwrites.
- Not defined: both ports and their registers are absent; all other behaviour is identical.

## Test plan
- Clean run: FIFO preloaded with 0..29, defaults, `start` → 3 bursts of 10 `fifo_rd_req` cycles each, `done`=1, `pass`=1, `err_cnt`=0, `word_cnt`=30.
- Corrupted word: word 17 = 16'h0055 → `err_cnt`=1, `pass`=0. With the macro: `first_err_idx`=17, `first_err_data`=16'h0055.
- Starved FIFO: `rd_fifo_cnt` held at 4 for 50 cycles, then 10 → `sdram_rd_valid`=1 throughout the starve, 0 one cycle after cnt≥10, first `fifo_rd_req` the cycle after.
- Partial burst: TOTAL=25 → bursts of 10, 10, 5; `word_cnt`=25.
- Reset mid-DRAIN: assert `locked_rst_n`=0 after the 4th read → all outputs at reset values immediately. `start` after release → fresh run, `word_cnt` counts from 0.
- Saturation and wrap: PATTERN_BASE=16'hFFFE with data 16'hFFFE, 16'hFFFF, 0, 1… → `pass`=1. All-wrong data with TOTAL=70000 → `err_cnt`=16'hFFFF.

Source files
------------

// File: rtl/sdram_rd_checker.sv
// Read-back checker: drains the SDRAM read FIFO in bursts and compares each word
// against an incrementing pattern. Define SDRAM_RD_CHK_FIRST_ERR_EN to capture the first mismatch.
module sdram_rd_checker #(
    parameter int unsigned        DATA_W       = 16,
    parameter int unsigned        CNT_W        = 10,
    parameter int unsigned        BURST        = 10,
    parameter int unsigned        TOTAL        = 30,
    parameter logic [DATA_W-1:0]  PATTERN_BASE = '0
) (
    input  logic              clk_50M,
    input  logic              locked_rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  rd_fifo_cnt,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_req,
    output logic              sdram_rd_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [15:0]       word_cnt,
`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
    output logic [15:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
`endif
    output logic [2:0]        dbg_state
);

    // Handshake: fifo_rd_req is a registered read strobe; the FIFO answers with
    // fifo_rd_data one cycle later, which is when chk_vld_q compares it.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_DRAIN = 3'd2,
        S_TAIL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] issued_q, issued_d;
    logic [31:0] words_q, words_d;
    logic [31:0] rd_left_q, rd_left_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        fifo_rd_req_q, fifo_rd_req_d;
    logic        sdram_rd_valid_q, sdram_rd_valid_d;
    logic        chk_vld_q, chk_vld_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic [31:0]       remaining;
    logic [31:0]       burst_len;
    logic [DATA_W-1:0] exp_word;
    logic              mismatch;
    logic              fifo_ready;

`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
    logic              first_err_seen_q, first_err_seen_d;
    logic [15:0]       first_err_idx_q, first_err_idx_d;
    logic [DATA_W-1:0] first_err_data_q, first_err_data_d;
`endif

    always_comb begin
        remaining  = TOTAL - issued_q;
        burst_len  = (remaining < BURST) ? remaining : BURST;
        exp_word   = PATTERN_BASE + DATA_W'(words_q);
        mismatch   = chk_vld_q && (fifo_rd_data != exp_word);
        fifo_ready = (32'(rd_fifo_cnt) >= burst_len);

        state_d   = state_q;
        issued_d  = issued_q;
        words_d   = words_q;
        rd_left_d = rd_left_q;
        err_cnt_d = err_cnt_q;
        chk_vld_d = fifo_rd_req_q;
`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
        first_err_seen_d = first_err_seen_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_data_d = first_err_data_q;
        if (mismatch && !first_err_seen_q) begin
            first_err_seen_d = 1'b1;
            first_err_idx_d  = words_q[15:0];
            first_err_data_d = fifo_rd_data;
        end
`endif

        if (chk_vld_q) begin
            words_d = words_q + 32'd1;
            if (mismatch && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_ARM;
                    issued_d  = '0;
                    words_d   = '0;
                    err_cnt_d = '0;
`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
                    first_err_seen_d = 1'b0;
                    first_err_idx_d  = '0;
                    first_err_data_d = '0;
`endif
                end
            end
            S_ARM: begin
                if (fifo_ready) begin
                    state_d   = S_DRAIN;
                    rd_left_d = burst_len;
                    issued_d  = issued_q + burst_len;
                end
            end
            S_DRAIN: begin
                rd_left_d = rd_left_q - 32'd1;
                if (rd_left_q == 32'd1) begin
                    state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                // words_d already includes the last word of the burst
                state_d = (words_d < TOTAL) ? S_ARM : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        fifo_rd_req_d    = (state_d == S_DRAIN);
        sdram_rd_valid_d = (state_q == S_ARM) && !fifo_ready;
        busy_d           = (state_d == S_ARM) || (state_d == S_DRAIN) || (state_d == S_TAIL);
        done_d           = (state_d == S_DONE);
        pass_d           = done_d && (err_cnt_d == 16'd0);
    end

    always_ff @(posedge clk_50M or negedge locked_rst_n) begin
        if (!locked_rst_n) begin
            state_q          <= S_IDLE;
            issued_q         <= '0;
            words_q          <= '0;
            rd_left_q        <= '0;
            err_cnt_q        <= '0;
            fifo_rd_req_q    <= 1'b0;
            sdram_rd_valid_q <= 1'b0;
            chk_vld_q        <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
            first_err_seen_q <= 1'b0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
`endif
        end else begin
            state_q          <= state_d;
            issued_q         <= issued_d;
            words_q          <= words_d;
            rd_left_q        <= rd_left_d;
            err_cnt_q        <= err_cnt_d;
            fifo_rd_req_q    <= fifo_rd_req_d;
            sdram_rd_valid_q <= sdram_rd_valid_d;
            chk_vld_q        <= chk_vld_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
            first_err_seen_q <= first_err_seen_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_data_q <= first_err_data_d;
`endif
        end
    end

    assign fifo_rd_req    = fifo_rd_req_q;
    assign sdram_rd_valid = sdram_rd_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign word_cnt       = words_q[15:0];
    assign dbg_state      = state_q;
`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;
`endif

endmodule
